// File: rtl/out_arbiter_3port_pkg.sv
// Shared definitions for the 3-port output arbiter: crossbar select codes,
// port indices, FSM states and small port-index helpers.
package out_arbiter_3port_pkg;

  localparam logic [2:0] SW_STOP  = 3'd0;
  localparam logic [2:0] SW_X1    = 3'd1;
  localparam logic [2:0] SW_Y1    = 3'd2;
  localparam logic [2:0] SW_LOCAL = 3'd3;

  localparam logic [1:0] PORT_X     = 2'd0;
  localparam logic [1:0] PORT_Y     = 2'd1;
  localparam logic [1:0] PORT_LOCAL = 2'd2;
  localparam logic [1:0] PORT_NONE  = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Port index addition modulo 3; operands are expected in 0..2.
  function automatic logic [1:0] port_add(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [2:0] port_onehot(input logic [1:0] p);
    case (p)
      PORT_X:     return 3'b001;
      PORT_Y:     return 3'b010;
      PORT_LOCAL: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/out_arbiter_3port_if.sv
// Request/grant bundle between the three input buffers, the output unit
// and the output-port arbiter.
interface out_arbiter_3port_if;
  import out_arbiter_3port_pkg::*;

  logic       full;
  logic       req_x;
  logic       req_y;
  logic       req_local;
  logic       tail_x;
  logic       tail_y;
  logic       tail_local;
  logic [2:0] port_sw_id;
  logic       grant_x;
  logic       grant_y;
  logic       grant_local;
  logic       locked;
  logic [1:0] owner;

  modport master (
    output full, req_x, req_y, req_local, tail_x, tail_y, tail_local,
    input  port_sw_id, grant_x, grant_y, grant_local, locked, owner
  );

  modport slave (
    input  full, req_x, req_y, req_local, tail_x, tail_y, tail_local,
    output port_sw_id, grant_x, grant_y, grant_local, locked, owner
  );
endinterface

// File: rtl/out_arbiter_3port_rr_arb3.sv
// Combinational 3-way round-robin pick: the first requester found starting
// at prio and wrapping through the other two ports.
module rr_arb3
  import out_arbiter_3port_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] prio,
  output logic [2:0] gnt_onehot,
  output logic [1:0] gnt_idx
);

  logic [3:0] req_pad;
  logic [1:0] base;
  logic [1:0] cand;
  logic       found;

  assign req_pad = {1'b0, req};

  // A stray prio of 3 falls back to X as the highest-priority port.
  always_comb begin
    gnt_onehot = 3'b000;
    gnt_idx    = PORT_NONE;
    found      = 1'b0;
    cand       = PORT_X;
    base       = (prio == PORT_NONE) ? PORT_X : prio;
    for (int k = 0; k < 3; k++) begin
      cand = port_add(base, 2'(k));
      if (!found && req_pad[cand]) begin
        gnt_onehot = port_onehot(cand);
        gnt_idx    = cand;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/out_arbiter_3port.sv
// Switch allocator for one 3-input router output port: packet-level
// round-robin with a wormhole lock held from head flit to tail flit.
module out_arbiter_3port
  import out_arbiter_3port_pkg::*;
#(
  parameter bit LOCK_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  out_arbiter_3port_if.slave   bus
);

  arb_state_e state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] prio_q, prio_d;
  logic [2:0] gnt;
  logic [2:0] gnt_q;
  logic [2:0] rr_onehot;
  logic [1:0] rr_idx;
  logic [3:0] req_vec;
  logic [3:0] tail_vec;

  assign req_vec  = {1'b0, bus.req_local, bus.req_y, bus.req_x};
  assign tail_vec = {1'b0, bus.tail_local, bus.tail_y, bus.tail_x};

  rr_arb3 u_rr_arb3 (
    .req        (req_vec[2:0]),
    .prio       (prio_q),
    .gnt_onehot (rr_onehot),
    .gnt_idx    (rr_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= PORT_NONE;
      prio_q  <= PORT_X;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  // Nothing moves while the output unit is full, so a tail blocked by
  // backpressure keeps the lock until it is actually granted.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = (prio_q == PORT_NONE) ? PORT_X : prio_q;
    gnt     = 3'b000;
    if (!bus.full) begin
      case (state_q)
        ST_IDLE: begin
          if (rr_idx != PORT_NONE) begin
            gnt = rr_onehot;
            if (tail_vec[rr_idx] || !LOCK_EN) begin
              prio_d = port_add(rr_idx, 2'd1);
            end else begin
              state_d = ST_LOCKED;
              owner_d = rr_idx;
            end
          end
        end
        ST_LOCKED: begin
          if (req_vec[owner_q]) begin
            gnt = port_onehot(owner_q);
            if (tail_vec[owner_q]) begin
              state_d = ST_IDLE;
              owner_d = PORT_NONE;
              prio_d  = port_add(owner_q, 2'd1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          owner_d = PORT_NONE;
        end
      endcase
    end
  end

  assign gnt_q = gnt & {3{rst_n}};

  always_comb begin
    case (gnt_q)
      3'b001:  bus.port_sw_id = SW_X1;
      3'b010:  bus.port_sw_id = SW_Y1;
      3'b100:  bus.port_sw_id = SW_LOCAL;
      default: bus.port_sw_id = SW_STOP;
    endcase
  end

  assign bus.grant_x     = gnt_q[0];
  assign bus.grant_y     = gnt_q[1];
  assign bus.grant_local = gnt_q[2];
  assign bus.locked      = (state_q == ST_LOCKED);
  assign bus.owner       = owner_q;

endmodule

// File: tb/tb_out_arbiter_3port.sv
// Bench for out_arbiter_3port: a locking and a non-locking instance share the
// same stimulus and are compared against a port-level arbitration model.
module tb_out_arbiter_3port;
  import out_arbiter_3port_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  out_arbiter_3port_if ifa ();
  out_arbiter_3port_if ifb ();

  out_arbiter_3port #(.LOCK_EN(1'b1)) dut_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  out_arbiter_3port #(.LOCK_EN(1'b0)) dut_nolock (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: one entry per instance (0 = locking, 1 = non-locking).
  bit m_locked[2];
  int m_owner[2];
  int m_prio[2];
  bit m_lock_en[2] = '{1'b1, 1'b0};

  logic [2:0] cur_r, cur_t;
  logic       cur_f;
  int         exp_idx[2];
  logic [2:0] exp_gnt[2], exp_sw[2], obs_gnt[2], obs_sw[2];
  logic       exp_locked[2], obs_locked[2];
  logic [1:0] exp_owner[2], obs_owner[2];

  function automatic int pick(int d, logic [2:0] r, logic f);
    if (f) return -1;
    if (m_locked[d]) return r[m_owner[d]] ? m_owner[d] : -1;
    for (int i = 0; i < 3; i++)
      if (r[(m_prio[d] + i) % 3]) return (m_prio[d] + i) % 3;
    return -1;
  endfunction

  function automatic logic [2:0] sw_of(int idx);
    case (idx)
      0:       return SW_X1;
      1:       return SW_Y1;
      2:       return SW_LOCAL;
      default: return SW_STOP;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_locked[d] = 1'b0;
      m_owner[d]  = 3;
      m_prio[d]   = 0;
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] t, input logic f);
    cur_r = r; cur_t = t; cur_f = f;
    {ifa.req_local, ifa.req_y, ifa.req_x}    = r;
    {ifa.tail_local, ifa.tail_y, ifa.tail_x} = t;
    ifa.full = f;
    {ifb.req_local, ifb.req_y, ifb.req_x}    = r;
    {ifb.tail_local, ifb.tail_y, ifb.tail_x} = t;
    ifb.full = f;
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_idx[d]    = pick(d, r, f);
      exp_gnt[d]    = (exp_idx[d] < 0) ? 3'b000 : 3'(1 << exp_idx[d]);
      exp_sw[d]     = sw_of(exp_idx[d]);
      exp_locked[d] = m_locked[d];
      exp_owner[d]  = 2'(m_owner[d]);
    end
    obs_gnt[0] = {ifa.grant_local, ifa.grant_y, ifa.grant_x};
    obs_sw[0] = ifa.port_sw_id; obs_locked[0] = ifa.locked; obs_owner[0] = ifa.owner;
    obs_gnt[1] = {ifb.grant_local, ifb.grant_y, ifb.grant_x};
    obs_sw[1] = ifb.port_sw_id; obs_locked[1] = ifb.locked; obs_owner[1] = ifb.owner;
  endtask

  // Advances the model across one clock edge using the inputs just driven.
  task automatic tick();
    int w;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      w = exp_idx[d];
      if (w >= 0) begin
        if (m_locked[d]) begin
          if (cur_t[w]) begin
            m_locked[d] = 1'b0;
            m_owner[d]  = 3;
            m_prio[d]   = (w + 1) % 3;
          end
        end else if (cur_t[w] || !m_lock_en[d]) begin
          m_prio[d] = (w + 1) % 3;
        end else begin
          m_locked[d] = 1'b1;
          m_owner[d]  = w;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    {ifa.req_local, ifa.req_y, ifa.req_x} = 3'b111;
    {ifa.tail_local, ifa.tail_y, ifa.tail_x} = 3'b111;
    ifa.full = 1'b0;
    {ifb.req_local, ifb.req_y, ifb.req_x} = 3'b111;
    {ifb.tail_local, ifb.tail_y, ifb.tail_x} = 3'b111;
    ifb.full = 1'b0;
    #12;
    tests_run++;
    if ({ifa.port_sw_id, ifa.grant_local, ifa.grant_y, ifa.grant_x, ifa.locked, ifa.owner} !==
        {SW_STOP, 3'b000, 1'b0, PORT_NONE}) begin
      tests_failed++;
      $display("[TB] FAIL reset_lock: sw=%0d gnt=%b locked=%b owner=%0d, expected sw=0 gnt=000 locked=0 owner=3",
               ifa.port_sw_id, {ifa.grant_local, ifa.grant_y, ifa.grant_x}, ifa.locked, ifa.owner);
    end
    tests_run++;
    if ({ifb.port_sw_id, ifb.grant_local, ifb.grant_y, ifb.grant_x, ifb.locked, ifb.owner} !==
        {SW_STOP, 3'b000, 1'b0, PORT_NONE}) begin
      tests_failed++;
      $display("[TB] FAIL reset_nolock: sw=%0d gnt=%b locked=%b owner=%0d, expected sw=0 gnt=000 locked=0 owner=3",
               ifb.port_sw_id, {ifb.grant_local, ifb.grant_y, ifb.grant_x}, ifb.locked, ifb.owner);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_round_robin();
    logic [2:0] seq[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    for (int c = 0; c < 4; c++) begin
      drive(3'b111, 3'b111, 1'b0);
      for (int d = 0; d < 2; d++) begin
        tests_run++;
        if ({obs_sw[d], obs_gnt[d], obs_locked[d], obs_owner[d]} !==
            {exp_sw[d], exp_gnt[d], exp_locked[d], exp_owner[d]}) begin
          tests_failed++;
          $display("[TB] FAIL rr dut%0d c%0d: sw=%0d gnt=%b lk=%b own=%0d, expected sw=%0d gnt=%b lk=%b own=%0d",
                   d, c, obs_sw[d], obs_gnt[d], obs_locked[d], obs_owner[d],
                   exp_sw[d], exp_gnt[d], exp_locked[d], exp_owner[d]);
        end
      end
      tests_run++;
      if (obs_gnt[0] !== seq[c]) begin
        tests_failed++;
        $display("[TB] FAIL rr_order c%0d: gnt=%b, expected %b", c, obs_gnt[0], seq[c]);
      end
      tick();
    end
  endtask

  task automatic test_lock_packet();
    int left = 4;
    for (int c = 0; c < 6; c++) begin
      drive({left > 0, 1'b0, 1'b1}, {left == 1, 1'b0, 1'b1}, 1'b0);
      for (int d = 0; d < 2; d++) begin
        tests_run++;
        if ({obs_sw[d], obs_gnt[d], obs_locked[d], obs_owner[d]} !==
            {exp_sw[d], exp_gnt[d], exp_locked[d], exp_owner[d]}) begin
          tests_failed++;
          $display("[TB] FAIL lock_pkt dut%0d c%0d: sw=%0d gnt=%b lk=%b own=%0d, expected sw=%0d gnt=%b lk=%b own=%0d",
                   d, c, obs_sw[d], obs_gnt[d], obs_locked[d], obs_owner[d],
                   exp_sw[d], exp_gnt[d], exp_locked[d], exp_owner[d]);
        end
      end
      if (c <= 4) begin
        tests_run++;
        if (obs_gnt[0] !== ((c < 4) ? 3'b100 : 3'b001)) begin
          tests_failed++;
          $display("[TB] FAIL lock_pkt_order c%0d: gnt=%b, expected %b", c, obs_gnt[0],
                   (c < 4) ? 3'b100 : 3'b001);
        end
      end
      if (exp_idx[0] == 2) left--;
      tick();
    end
  endtask

  task automatic test_bubble();
    int  left = 4;
    logic yr;
    for (int c = 0; c < 7; c++) begin
      yr = (left > 0) && !(c == 2 || c == 3);
      drive({1'b0, yr, 1'b1}, {1'b0, left == 1, 1'b1}, 1'b0);
      for (int d = 0; d < 2; d++) begin
        tests_run++;
        if ({obs_sw[d], obs_gnt[d], obs_locked[d], obs_owner[d]} !==
            {exp_sw[d], exp_gnt[d], exp_locked[d], exp_owner[d]}) begin
          tests_failed++;
          $display("[TB] FAIL bubble dut%0d c%0d: sw=%0d gnt=%b lk=%b own=%0d, expected sw=%0d gnt=%b lk=%b own=%0d",
                   d, c, obs_sw[d], obs_gnt[d], obs_locked[d], obs_owner[d],
                   exp_sw[d], exp_gnt[d], exp_locked[d], exp_owner[d]);
        end
      end
      if (c == 2 || c == 3) begin
        tests_run++;
        if ({obs_sw[0], obs_gnt[0]} !== {SW_STOP, 3'b000}) begin
          tests_failed++;
          $display("[TB] FAIL bubble_stop c%0d: sw=%0d gnt=%b, expected sw=0 gnt=000", c, obs_sw[0], obs_gnt[0]);
        end
      end
      if (exp_idx[0] == 1) left--;
      tick();
    end
  endtask

  task automatic test_full_tail();
    int  left = 3;
    logic f;
    for (int c = 0; c < 7; c++) begin
      f = (c >= 2 && c <= 4);
      drive({1'b0, c >= 1, left > 0}, {1'b0, 1'b1, left == 1}, f);
      for (int d = 0; d < 2; d++) begin
        tests_run++;
        if ({obs_sw[d], obs_gnt[d], obs_locked[d], obs_owner[d]} !==
            {exp_sw[d], exp_gnt[d], exp_locked[d], exp_owner[d]}) begin
          tests_failed++;
          $display("[TB] FAIL full dut%0d c%0d: sw=%0d gnt=%b lk=%b own=%0d, expected sw=%0d gnt=%b lk=%b own=%0d",
                   d, c, obs_sw[d], obs_gnt[d], obs_locked[d], obs_owner[d],
                   exp_sw[d], exp_gnt[d], exp_locked[d], exp_owner[d]);
        end
      end
      if (c >= 2) begin
        tests_run++;
        if (obs_gnt[0] !== (f ? 3'b000 : ((c == 5) ? 3'b001 : 3'b010))) begin
          tests_failed++;
          $display("[TB] FAIL full_order c%0d: gnt=%b, expected %b", c, obs_gnt[0],
                   f ? 3'b000 : ((c == 5) ? 3'b001 : 3'b010));
        end
      end
      if (exp_idx[0] == 0) left--;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(3'b010, 3'b000, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({ifa.port_sw_id, ifa.grant_local, ifa.grant_y, ifa.grant_x, ifa.locked, ifa.owner} !==
        {SW_STOP, 3'b000, 1'b0, PORT_NONE}) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: sw=%0d gnt=%b locked=%b owner=%0d, expected sw=0 gnt=000 locked=0 owner=3",
               ifa.port_sw_id, {ifa.grant_local, ifa.grant_y, ifa.grant_x}, ifa.locked, ifa.owner);
    end
    model_reset();
    #1;
    rst_n = 1'b1;
    drive(3'b111, 3'b111, 1'b0);
    tests_run++;
    if ({obs_sw[0], obs_gnt[0]} !== {SW_X1, 3'b001}) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_first: sw=%0d gnt=%b, expected sw=%0d gnt=001", obs_sw[0], obs_gnt[0], SW_X1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int xl = 3;
    int yl = 3;
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive({1'b0, yl > 0, xl > 0}, {1'b0, yl == 1, xl == 1}, 1'b0);
      for (int d = 0; d < 2; d++) begin
        tests_run++;
        if ({obs_sw[d], obs_gnt[d], obs_locked[d], obs_owner[d]} !==
            {exp_sw[d], exp_gnt[d], exp_locked[d], exp_owner[d]}) begin
          tests_failed++;
          $display("[TB] FAIL b2b dut%0d c%0d: sw=%0d gnt=%b lk=%b own=%0d, expected sw=%0d gnt=%b lk=%b own=%0d",
                   d, c, obs_sw[d], obs_gnt[d], obs_locked[d], obs_owner[d],
                   exp_sw[d], exp_gnt[d], exp_locked[d], exp_owner[d]);
        end
      end
      tests_run++;
      if (obs_gnt[1] !== ((c % 2 == 0) ? 3'b001 : 3'b010)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_interleave c%0d: gnt=%b, expected %b", c, obs_gnt[1],
                 (c % 2 == 0) ? 3'b001 : 3'b010);
      end
      if (exp_idx[1] == 0) xl--;
      if (exp_idx[1] == 1) yl--;
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0));
      for (int d = 0; d < 2; d++) begin
        tests_run++;
        if ({obs_sw[d], obs_gnt[d], obs_locked[d], obs_owner[d]} !==
            {exp_sw[d], exp_gnt[d], exp_locked[d], exp_owner[d]}) begin
          tests_failed++;
          $display("[TB] FAIL random dut%0d c%0d: sw=%0d gnt=%b lk=%b own=%0d, expected sw=%0d gnt=%b lk=%b own=%0d",
                   d, c, obs_sw[d], obs_gnt[d], obs_locked[d], obs_owner[d],
                   exp_sw[d], exp_gnt[d], exp_locked[d], exp_owner[d]);
        end
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_lock_packet();
    test_bubble();
    test_full_tail();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
